// File: rtl/nn_ctrl_pkg.sv
// Shared controller definitions for the NN inference datapath: FSM states,
// main_memory index widths and the per-layer input-count field decode.
package nn_ctrl_pkg;

  localparam int NEURONS    = 4;
  localparam int MEM_IDX_W  = 6;
  localparam int K_W        = 2;
  localparam int LI_FIELD_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    BURST,
    GAP,
    ACT,
    WAIT
  } state_t;

  // Index of the last input burst for a layer; a zero field runs one burst
  // and anything above NEURONS is clamped so i never leaves the k range.
  function automatic logic [K_W-1:0] last_input(input logic [LI_FIELD_W-1:0] field);
    if (field == '0) begin
      return '0;
    end else if (field > LI_FIELD_W'(NEURONS)) begin
      return K_W'(NEURONS - 1);
    end else begin
      return K_W'(field - 1'b1);
    end
  endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Control and strobe bundle between layer_sequencer (master) and the
// main_memory / MAC array / activation consumers (slave).
interface layer_sequencer_if;
  import nn_ctrl_pkg::*;

  logic                 start;
  logic                 act_done;
  logic [MEM_IDX_W-1:0] n;
  logic [MEM_IDX_W-1:0] i;
  logic                 weight_en;
  logic                 bias_en;
  logic                 wt_valid;
  logic [K_W-1:0]       wt_neuron;
  logic [K_W-1:0]       wt_input;
  logic                 bias_valid;
  logic [2:0]           layer_idx;
  logic                 act_start;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, act_done,
    output n, i, weight_en, bias_en, wt_valid, wt_neuron, wt_input,
           bias_valid, layer_idx, act_start, busy, done
  );

  modport slave (
    output start, act_done,
    input  n, i, weight_en, bias_en, wt_valid, wt_neuron, wt_input,
           bias_valid, layer_idx, act_start, busy, done
  );

endinterface

// File: rtl/layer_sequencer.sv
// Walks layers and input bursts for main_memory, emits MAC strobes one cycle
// behind the read enables, and hands each layer to the activation stage.
module layer_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int                                NUM_LAYERS   = 2,
  parameter logic [LI_FIELD_W*NUM_LAYERS-1:0]  LAYER_INPUTS = {3'd2, 3'd4}
) (
  input  logic               clk,
  input  logic               rst,
  layer_sequencer_if.master  bus
);

  state_t         state, state_nxt;
  logic [K_W-1:0] beat;
  logic [K_W-1:0] inp;
  logic [K_W-1:0] inp_last;
  logic [2:0]     layer;
  logic           layer_last;
  logic           done_q;
  logic           weight_en;
  logic           bias_en;

  assign inp_last   = last_input(LAYER_INPUTS[LI_FIELD_W*int'(layer) +: LI_FIELD_W]);
  assign layer_last = (layer == 3'(NUM_LAYERS - 1));

  // NOTE: state and counters use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    weight_en = 1'b0;
    bias_en   = 1'b0;
    case (state)
      IDLE:  if (bus.start) state_nxt = BURST;
      BURST: begin
        weight_en = 1'b1;
        bias_en   = (inp == '0);
        if (beat == K_W'(NEURONS - 1)) state_nxt = GAP;
      end
      GAP:   state_nxt = (inp < inp_last) ? BURST : ACT;
      ACT:   state_nxt = WAIT;
      WAIT:  if (bus.act_done) state_nxt = layer_last ? IDLE : BURST;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat           <= '0;
      inp            <= '0;
      layer          <= '0;
      done_q         <= 1'b0;
      bus.wt_valid   <= 1'b0;
      bus.wt_neuron  <= '0;
      bus.wt_input   <= '0;
      bus.bias_valid <= 1'b0;
    end else begin
      // beat tracks main_memory's k, which only advances while weight_en is high
      beat   <= (state == BURST) ? beat + 1'b1 : '0;
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          layer <= '0;
          inp   <= '0;
        end
        GAP: if (inp < inp_last) inp <= inp + 1'b1;
        WAIT: if (bus.act_done) begin
          inp <= '0;
          if (layer_last) begin
            layer  <= '0;
            done_q <= 1'b1;
          end else begin
            layer <= layer + 1'b1;
          end
        end
        default: ;
      endcase
      // memory read latency is one cycle, so the MAC strobes trail the enables
      bus.wt_valid   <= weight_en;
      bus.wt_neuron  <= beat;
      bus.wt_input   <= inp;
      bus.bias_valid <= bias_en;
    end
  end

  assign bus.n         = MEM_IDX_W'(layer);
  assign bus.i         = MEM_IDX_W'(inp);
  assign bus.weight_en = weight_en;
  assign bus.bias_en   = bias_en;
  assign bus.layer_idx = layer;
  assign bus.act_start = (state == ACT);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench: a cycle-trace model built from the layer/burst rules
// is compared against two sequencer configurations under random stimulus.
module tb_layer_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic start_r = 1'b0;
  logic act_done_r = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  layer_sequencer_if bus0 ();
  layer_sequencer_if bus1 ();

  assign bus0.start    = start_r && !sel;
  assign bus0.act_done = act_done_r && !sel;
  assign bus1.start    = start_r && sel;
  assign bus1.act_done = act_done_r && sel;

  layer_sequencer dut0 (.clk(clk), .rst(rst), .bus(bus0));

  layer_sequencer #(.NUM_LAYERS(2), .LAYER_INPUTS({3'd1, 3'd0})) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  localparam logic [5:0] CFG0 = {3'd2, 3'd4};
  localparam logic [5:0] CFG1 = {3'd1, 3'd0};

  typedef struct packed {
    logic [5:0] n;
    logic [5:0] i;
    logic       we;
    logic       be;
    logic       wv;
    logic [1:0] wn;
    logic [1:0] wi;
    logic       bv;
    logic [2:0] li;
    logic       as;
    logic       busy;
    logic       done;
  } obs_t;

  // Abstract per-cycle view of what the memory side should see.
  typedef struct packed {
    logic       we;
    logic       be;
    logic [2:0] n;
    logic [1:0] i;
    logic [1:0] k;
    logic       as;
    logic       busy;
    logic       done;
  } raw_t;

  raw_t exp_q[$];
  bit   st_q[$];
  bit   ad_q[$];
  int   span_q[$];

  function automatic int inputs_of(input logic s, input int l);
    logic [5:0] cfg;
    int f;
    cfg = s ? CFG1 : CFG0;
    f = int'(cfg[3*l +: 3]);
    return (f == 0) ? 1 : f;
  endfunction

  function automatic raw_t mk(bit we, bit be, int n, int i, int k, bit as, bit busy, bit done);
    raw_t r;
    r.we = we; r.be = be; r.n = 3'(n); r.i = 2'(i); r.k = 2'(k);
    r.as = as; r.busy = busy; r.done = done;
    return r;
  endfunction

  function automatic obs_t expect_of(raw_t cur, raw_t prev);
    obs_t e;
    e.n = {3'b0, cur.n};  e.i = {4'b0, cur.i};
    e.we = cur.we;        e.be = cur.be;
    e.wv = prev.we;       e.wn = prev.we ? prev.k : 2'b0;
    e.wi = prev.i;        e.bv = prev.be;
    e.li = cur.n;         e.as = cur.as;
    e.busy = cur.busy;    e.done = cur.done;
    return e;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    if (sel) begin
      o.n = bus1.n; o.i = bus1.i; o.we = bus1.weight_en; o.be = bus1.bias_en;
      o.wv = bus1.wt_valid; o.wn = bus1.wt_neuron; o.wi = bus1.wt_input;
      o.bv = bus1.bias_valid; o.li = bus1.layer_idx; o.as = bus1.act_start;
      o.busy = bus1.busy; o.done = bus1.done;
    end else begin
      o.n = bus0.n; o.i = bus0.i; o.we = bus0.weight_en; o.be = bus0.bias_en;
      o.wv = bus0.wt_valid; o.wn = bus0.wt_neuron; o.wi = bus0.wt_input;
      o.bv = bus0.bias_valid; o.li = bus0.layer_idx; o.as = bus0.act_start;
      o.busy = bus0.busy; o.done = bus0.done;
    end
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Builds the full expected trace of one inference plus the inputs driven
  // in each cycle; hold < 0 picks a random WAIT length per layer.
  task automatic build(input bit inject, input int hold);
    exp_q.delete(); st_q.delete(); ad_q.delete();
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); st_q.push_back(1); ad_q.push_back(0);
    for (int l = 0; l < 2; l++) begin
      int ni = inputs_of(sel, l);
      int w;
      for (int j = 0; j < ni; j++) begin
        for (int k = 0; k < 4; k++) begin
          exp_q.push_back(mk(1, j == 0, l, j, k, 0, 1, 0));
          st_q.push_back(inject ? bit'($urandom % 2) : 1'b0);
          ad_q.push_back(inject ? bit'($urandom % 2) : 1'b0);
        end
        exp_q.push_back(mk(0, 0, l, j, 0, 0, 1, 0));
        st_q.push_back(inject ? bit'($urandom % 2) : 1'b0);
        ad_q.push_back(inject ? bit'($urandom % 2) : 1'b0);
      end
      // act_done coincident with act_start must not be taken
      exp_q.push_back(mk(0, 0, l, ni - 1, 0, 1, 1, 0));
      st_q.push_back(inject); ad_q.push_back(1);
      w = (hold >= 0) ? hold : int'($urandom_range(0, 6));
      for (int c = 0; c < w; c++) begin
        exp_q.push_back(mk(0, 0, l, ni - 1, 0, 0, 1, 0));
        st_q.push_back(0); ad_q.push_back(0);
      end
      exp_q.push_back(mk(0, 0, l, ni - 1, 0, 0, 1, 0));
      st_q.push_back(0); ad_q.push_back(1);
    end
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1)); st_q.push_back(0); ad_q.push_back(0);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); st_q.push_back(0); ad_q.push_back(0);
  endtask

  // Plays the trace, comparing every cycle; stops early before cycle abort_at.
  task automatic sequence_run(input string label, input bit inject, input int hold,
                              input int abort_at);
    raw_t prev;
    int   layer_start;
    bit   in_layer;
    prev = mk(0, 0, 0, 0, 0, 0, 0, 0);
    layer_start = 0;
    in_layer = 0;
    span_q.delete();
    build(inject, hold);
    for (int c = 0; c < exp_q.size(); c++) begin
      obs_t o, e;
      if (c == abort_at) return;
      o = observe();
      e = expect_of(exp_q[c], prev);
      if (!e.wv) o.wn = 2'b0;
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL %s cycle %0d: got %h expected %h", label, c, o, e);
      end
      if (o.we && !in_layer) begin
        layer_start = c;
        in_layer = 1;
      end
      if (o.as) begin
        span_q.push_back(c - layer_start);
        in_layer = 0;
      end
      prev = exp_q[c];
      start_r = st_q[c];
      act_done_r = ad_q[c];
      step();
    end
    start_r = 0;
    act_done_r = 0;
  endtask

  task automatic test_reset();
    obs_t o;
    sel = 0;
    rst = 1;
    start_r = 1;
    step();
    o = observe();
    tests++;
    if (o !== obs_t'('0)) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected %h", o, obs_t'('0));
    end
    rst = 0;
    start_r = 0;
    step();
    o = observe();
    tests++;
    if (o.busy !== 1'b0 || o.we !== 1'b0) begin
      fails++;
      $display("FAIL start_with_reset: busy %b weight_en %b expected 0 0", o.busy, o.we);
    end
  endtask

  task automatic test_full_run();
    sel = 0;
    sequence_run("full_run", 0, 10, -1);
    tests++;
    if (span_q.size() != 2 || span_q[0] != 20 || span_q[1] != 10) begin
      fails++;
      $display("FAIL full_run_spans: got %p expected '{20, 10}", span_q);
    end
  endtask

  task automatic test_ignored_inputs();
    sel = 0;
    sequence_run("ignored_inputs", 1, -1, -1);
    tests++;
    if (span_q.size() != 2 || span_q[0] != 20 || span_q[1] != 10) begin
      fails++;
      $display("FAIL ignored_inputs_spans: got %p expected '{20, 10}", span_q);
    end
  endtask

  task automatic test_reset_mid_burst();
    obs_t o;
    sel = 0;
    sequence_run("pre_reset", 0, 0, 7);
    rst = 1;
    #1;
    o = observe();
    tests++;
    if (o !== obs_t'('0)) begin
      fails++;
      $display("FAIL reset_mid_burst: got %h expected %h", o, obs_t'('0));
    end
    step();
    rst = 0;
    step();
    sequence_run("after_reset", 0, -1, -1);
  endtask

  task automatic test_short_layers();
    sel = 1;
    step();
    sequence_run("short_layers", 0, -1, -1);
    tests++;
    if (span_q.size() != 2 || span_q[0] != 5 || span_q[1] != 5) begin
      fails++;
      $display("FAIL short_layers_spans: got %p expected '{5, 5}", span_q);
    end
    sel = 0;
  endtask

  task automatic test_back_to_back();
    sel = 0;
    for (int r = 0; r < 3; r++) begin
      sequence_run("back_to_back", bit'(r % 2), -1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_ignored_inputs();
    test_reset_mid_burst();
    test_short_layers();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Controller for main_memory in the NN inference datapath.
- Walks layers and inputs, driving n and i (layer and input index), plus weight_en and bias_en bursts, so that main_memory streams one weight per neuron per cycle.
- Emits aligned valid/index strobes to the MAC array, then hands each finished layer to the CORDIC activation stage through a start/done handshake before moving to the next layer.

Parameters:
- NUM_LAYERS, 2, number of layers sequenced, 1..8 (n is 3 bits at the memory).
- NEURONS, 4, weights per burst; fixed to 4 because main_memory's internal k counter is 2 bits.
- LAYER_INPUTS, {3'd2,3'd4}, packed per-layer input count; layer l uses bits [3l+2:3l]; legal values 1..4.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to run a full inference; accepted only in IDLE
- act_done  in  1  activation stage finished the current layer
- n  out  6  layer index to main_memory (upper bits 0)
- i  out  6  input index to main_memory (upper bits 0)
- weight_en  out  1  main_memory weight read enable
- bias_en  out  1  main_memory bias read enable
- wt_valid  out  1  main_memory wt_data is valid this cycle
- wt_neuron  out  2  neuron index of the current wt_data
- wt_input  out  2  input index of the current wt_data
- bias_valid  out  1  main_memory bias_data is valid this cycle (also acts as accumulator load)
- layer_idx  out  3  layer whose data is currently streaming
- act_start  out  1  one-cycle pulse: layer accumulation complete
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse: all layers complete

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-burst drops weight_en, which restarts main_memory's k counter on the next edge.
- States and transitions:
  - IDLE: on start, go to BURST with n=0, i=0, busy=1.
  - BURST: weight_en=1 for exactly NEURONS cycles; internal beat counter runs 0..3, mirroring main_memory k. bias_en=1 in the same cycles only when i==0. After beat 3, go to GAP.
  - GAP: one cycle with weight_en=0 and bias_en=0; main_memory requires this to clear k.
    - If i < LAYER_INPUTS[n]-1: i++, go to BURST.
    - Else: go to ACT.
  - ACT: act_start=1 for one cycle, go to WAIT.
  - WAIT: hold until act_done=1.
    - If n==NUM_LAYERS-1: done=1 for one cycle, busy=0, go to IDLE.
    - Else: n++, i=0, go to BURST.
- Memory has 1-cycle read latency, so the datapath strobes are registered one cycle behind the enables:
  - wt_valid is weight_en delayed one cycle.
  - wt_neuron is the beat counter delayed one cycle.
  - wt_input is i delayed one cycle.
  - bias_valid is bias_en delayed one cycle.
  - The last wt_valid of a layer therefore lands in the GAP cycle.
- Timing: a layer with I inputs occupies I*5 cycles from its first weight_en to act_start. act_start is asserted the cycle after the final GAP.
- n and i are stable throughout a burst and change only on the GAP→BURST or WAIT→BURST edge.
- Boundary conditions:
  - start outside IDLE is ignored.
  - start coincident with reset is ignored.
  - act_done outside WAIT is ignored.
  - act_done in the same cycle as act_start is not sampled; it must arrive in a later cycle.
  - A LAYER_INPUTS field of 0 is treated as 1.
  - layer_idx equals n; i never exceeds 3.

Decomposition:
- Shared package nn_ctrl_pkg holds:
  - state encoding (IDLE, BURST, GAP, ACT, WAIT);
  - NEURONS;
  - memory index widths (6-bit n/i, 2-bit k);
  - the LAYER_INPUTS field width (3).
- No sub-module; the FSM, counters and one-cycle output register stage all live in one module.

Test Plan:
- Reset, then start with defaults, main_memory attached → cycles 1-4 weight_en=1, bias_en=1, n=0, i=0. Next cycle wt_data=0x0040 with wt_neuron=0, then 0x0080, 0x0000, 0x0000. bias_valid data 0x0078, 0x0059, 0x0000, 0x0000.
- Layer 0 full run → four bursts with i=0..3, each followed by one low weight_en cycle. act_start asserted exactly 20 cycles after the first weight_en. i=1 burst returns 0x04CC, 0x063C, 0x0000, 0x0000.
- Hold act_done low for 10 cycles, then pulse it → no enables during WAIT. Next cycle: n=1, i=0, weight_en=1, first weight returned 0xF830. Layer 1 has 2 bursts, act_start after 10 cycles. After act_done, done pulses once and busy falls.
- start pulsed during BURST, and act_done pulsed during BURST → both ignored; sequence and cycle counts identical to the prior run.
- Assert rst during the second burst of layer 0 → all outputs 0 immediately. A new start produces first wt_data=0x0040 (memory k correctly restarted).
- LAYER_INPUTS={3'd1,3'd0}, NUM_LAYERS=2 → each layer runs a single burst. act_start is asserted 5 cycles after each layer's first weight_en.
